// File: rtl/riscv_pkg.sv
// Shared RV32 encoder constants: decoder mode codes, opcodes, EBREAK word, encoder FSM state.
// HALT exists only when INSTR_ENC_EBREAK_EN is defined.
package riscv_pkg;

  localparam logic [3:0] MODE_RESET  = 4'd0;
  localparam logic [3:0] MODE_R      = 4'd1;
  localparam logic [3:0] MODE_I      = 4'd2;
  localparam logic [3:0] MODE_LOAD   = 4'd3;
  localparam logic [3:0] MODE_STORE  = 4'd4;
  localparam logic [3:0] MODE_BRANCH = 4'd5;
  localparam logic [3:0] MODE_JAL    = 4'd6;
  localparam logic [3:0] MODE_LUI    = 4'd7;
  localparam logic [3:0] MODE_AUIPC  = 4'd8;
  localparam logic [3:0] MODE_JALR   = 4'd10;
  localparam logic [3:0] MODE_EBREAK = 4'd11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

`ifdef INSTR_ENC_EBREAK_EN
  typedef enum logic [1:0] {IDLE, RUN, HALT} enc_state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} enc_state_t;
`endif

endpackage

// File: rtl/instr_fifo2.sv
// Generic 2-entry valid/ready FIFO; head visible the cycle after a push into an empty FIFO.
// Backpressure: in_rdy low only when full and the head is not being popped; flush empties it.
module instr_fifo2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic [WIDTH-1:0] mem0, mem1;
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count;
  logic             push, pop;

  assign out_vld = (count != 2'd0);
  assign in_rdy  = (count != 2'd2) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = rd_ptr ? mem1 : mem0;

  // When full, the write slot equals the head slot; the head is read out this cycle before it is overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= in_dat;
        else        mem0 <= in_dat;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: field bundle -> RV32 word + byte address through a 2-entry FIFO, 1-cycle latency; EBREAK/HALT under INSTR_ENC_EBREAK_EN.
// Backpressure: in_ready low in reset, on clear, in HALT, or when the FIFO is full and out_ready is low.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic        halted
);
  import riscv_pkg::*;

  enc_state_t  state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] enc;
  logic        legal;
  logic        halt_st;
  logic        fifo_rdy;
  logic        accept, push;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (in_mode)
      MODE_RESET:  enc = '0;
      MODE_R:      enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      MODE_I:      enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
      MODE_LOAD:   enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      MODE_JALR:   enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_JALR};
      MODE_STORE:  enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      MODE_BRANCH: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], OP_BRANCH};
      MODE_JAL:    enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      MODE_LUI:    enc = {in_imm[31:12], in_rd, OP_LUI};
      MODE_AUIPC:  enc = {in_imm[31:12], in_rd, OP_AUIPC};
`ifdef INSTR_ENC_EBREAK_EN
      MODE_EBREAK: enc = EBREAK_WORD;
`endif
      default:     legal = 1'b0;
    endcase
  end

`ifdef INSTR_ENC_EBREAK_EN
  assign halt_st = (state_q == HALT);
`else
  assign halt_st = 1'b0;
`endif

  assign in_ready = rst_n && !clear && !halt_st && fifo_rdy;
  assign accept   = in_valid && in_ready;
  // Illegal bundles are consumed but never reach the FIFO or the address counter.
  assign push     = accept && legal;
  assign halted   = halt_st;

  always_comb begin
    state_d = state_q;
    if (push) begin
      state_d = RUN;
`ifdef INSTR_ENC_EBREAK_EN
      if (in_mode == MODE_EBREAK) state_d = HALT;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q     <= IDLE;
      addr_q      <= BASE_ADDR;
      err_illegal <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_illegal <= accept && !legal;
      if (push) addr_q <= addr_q + ADDR_STEP;
    end
  end

  instr_fifo2 #(.WIDTH(64)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .in_vld  (push),
    .in_rdy  (fifo_rdy),
    .in_dat  ({enc, addr_q}),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat ({out_instr, out_addr})
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized + directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

`ifdef INSTR_ENC_EBREAK_EN
  localparam bit EBREAK_EN = 1'b1;
`else
  localparam bit EBREAK_EN = 1'b0;
`endif
  localparam logic [31:0] STEP = 32'd4;
  localparam logic [31:0] WBASE = 32'hFFFF_FFFC;

  logic clk;
  logic rst_n, clear, in_valid, in_ready, out_valid, out_ready, err_illegal, halted;
  logic [3:0] in_mode;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [2:0] in_funct3;
  logic [6:0] in_funct7;
  logic [31:0] in_imm, out_instr, out_addr;

  logic w_rst_n, w_clear, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_err, w_halted;
  logic [31:0] w_out_instr, w_out_addr;

  int tests = 0;
  int fails = 0;

  bit [63:0]   q[$];
  bit [31:0]   m_addr;
  bit          m_halted, m_err;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_illegal(err_illegal), .halted(halted)
  );

  instr_encoder #(.BASE_ADDR(WBASE)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .clear(w_clear), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_mode(4'd1), .in_rd(5'd1), .in_rs1(5'd2), .in_rs2(5'd3),
    .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(32'd0),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr), .out_addr(w_out_addr),
    .err_illegal(w_err), .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_mode(input bit [3:0] m);
    return (m <= 4'd8) || (m == 4'd10) || (m == 4'd11 && EBREAK_EN);
  endfunction

  // Field placement written out from the ISA bit layouts with shifts and masks.
  function automatic bit [31:0] model_enc(input bit [3:0] m, input bit [31:0] rd, input bit [31:0] rs1,
                                          input bit [31:0] rs2, input bit [31:0] f3, input bit [31:0] f7,
                                          input bit [31:0] imm);
    bit [31:0] regs;
    regs = (rs1 << 15) | (f3 << 12);
    case (m)
      4'd1:  return (f7 << 25) | (rs2 << 20) | regs | (rd << 7) | 32'h33;
      4'd2:  return ((imm & 32'hFFF) << 20) | regs | (rd << 7) | 32'h13;
      4'd3:  return ((imm & 32'hFFF) << 20) | regs | (rd << 7) | 32'h03;
      4'd10: return ((imm & 32'hFFF) << 20) | regs | (rd << 7) | 32'h67;
      4'd4:  return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | regs | ((imm & 32'h1F) << 7) | 32'h23;
      4'd5:  return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | regs
                    | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      4'd6:  return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
      4'd7:  return (imm & 32'hFFFF_F000) | (rd << 7) | 32'h37;
      4'd8:  return (imm & 32'hFFFF_F000) | (rd << 7) | 32'h17;
      4'd11: return 32'h0010_0073;
      default: return 32'h0;
    endcase
  endfunction

  // One cycle: compare everything against the model, then advance the model on the clock edge.
  task automatic cyc();
    bit acc, pop;
    #1;
    chk1("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_instr", out_instr, q[0][63:32]);
      chk("out_addr", out_addr, q[0][31:0]);
    end
    chk1("in_ready", in_ready, rst_n && !clear && !m_halted && (q.size() < 2 || out_ready));
    chk1("halted", halted, m_halted);
    chk1("err_illegal", err_illegal, m_err);
    @(posedge clk);
    if (!rst_n || clear) begin
      q.delete();
      m_addr = 32'h0;
      m_halted = 1'b0;
      m_err = 1'b0;
    end else begin
      acc = in_valid && !m_halted && (q.size() < 2 || out_ready);
      pop = (q.size() > 0) && out_ready;
      m_err = acc && !legal_mode(in_mode);
      if (pop) void'(q.pop_front());
      if (acc && legal_mode(in_mode)) begin
        q.push_back({model_enc(in_mode, 32'(in_rd), 32'(in_rs1), 32'(in_rs2), 32'(in_funct3),
                               32'(in_funct7), in_imm), m_addr});
        m_addr = m_addr + STEP;
        if (in_mode == 4'd11) m_halted = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [3:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
    in_mode = m; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    w_rst_n = 1'b0; w_clear = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    m_addr = 32'h0; m_halted = 1'b0; m_err = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset_out_instr", out_instr, 32'h0);
    chk("reset_out_addr", out_addr, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // R-type
    set_fields(4'd1, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk1("rtype_valid", out_valid, 1'b1);
    chk("rtype_instr", out_instr, 32'h0031_00B3);
    chk("rtype_addr", out_addr, 32'h0);

    // Branch then a following word
    do_clear();
    set_fields(4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    in_valid = 1'b1;
    cyc();
    set_fields(4'd2, 5'd5, 5'd6, 5'd0, 3'd1, 7'd0, 32'h0000_0123);
    cyc();
    in_valid = 1'b0;
    chk("branch_instr", out_instr, 32'hFE20_8EE3);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("next_addr", out_addr, 32'h4);

    // Backpressure: three bundles with the sink stalled
    do_clear();
    set_fields(4'd1, 5'd7, 5'd8, 5'd9, 3'd2, 7'h20, 32'd0);
    in_valid = 1'b1;
    cyc(); cyc();
    #1 chk1("bp_in_ready_low", in_ready, 1'b0);
    cyc(); cyc();
    chk("bp_head0", out_addr, 32'h0);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("bp_head1", out_addr, 32'h4);
    cyc();
    chk("bp_head2", out_addr, 32'h8);
    cyc();
    out_ready = 1'b0;
    chk1("bp_drained", out_valid, 1'b0);

    // Illegal mode leaves the address alone
    set_fields(4'd9, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk1("illegal_pulse", err_illegal, 1'b1);
    chk1("illegal_no_valid", out_valid, 1'b0);
    set_fields(4'd7, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk1("illegal_pulse_end", err_illegal, 1'b0);
    chk("illegal_next_addr", out_addr, 32'hC);
    chk("lui_instr", out_instr, 32'hABCD_E1B7);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // EBREAK
    do_clear();
    set_fields(4'd11, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    cyc();
    set_fields(4'd1, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
`ifdef INSTR_ENC_EBREAK_EN
    chk("ebreak_instr", out_instr, 32'h0010_0073);
    chk1("ebreak_halted", halted, 1'b1);
    cyc(); cyc();
    out_ready = 1'b1;
    cyc(); cyc();
    out_ready = 1'b0;
    chk1("halt_held", halted, 1'b1);
    in_valid = 1'b0;
    do_clear();
    chk1("halt_cleared", halted, 1'b0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("after_clear_addr", out_addr, 32'h0);
`else
    in_valid = 1'b0;
    chk1("ebreak_illegal", err_illegal, 1'b1);
    chk1("ebreak_no_halt", halted, 1'b0);
    chk1("ebreak_no_valid", out_valid, 1'b0);
`endif
    out_ready = 1'b1;
    cyc(); cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 250) != 0);
      clear     = ($urandom_range(0, 60) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) in_mode = 4'($urandom_range(0, 15));
      else begin
        case ($urandom_range(0, 9))
          0: in_mode = 4'd0;  1: in_mode = 4'd1;  2: in_mode = 4'd2;  3: in_mode = 4'd3;
          4: in_mode = 4'd4;  5: in_mode = 4'd5;  6: in_mode = 4'd6;  7: in_mode = 4'd7;
          8: in_mode = 4'd8;  default: in_mode = 4'd10;
        endcase
      end
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_funct3 = 3'($urandom); in_funct7 = 7'($urandom); in_imm = $urandom;
      cyc();
    end
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();

    // Address wrap on the second instance
    w_rst_n = 1'b1;
    w_in_valid = 1'b1;
    cyc(); cyc();
    w_in_valid = 1'b0;
    chk1("wrap_valid", w_out_valid, 1'b1);
    chk("wrap_addr0", w_out_addr, 32'hFFFF_FFFC);
    w_out_ready = 1'b1;
    cyc();
    w_out_ready = 1'b0;
    chk("wrap_addr1", w_out_addr, 32'h0);
    w_in_valid = 1'b1;
    cyc();
    w_in_valid = 1'b0;
    #1 chk1("wrap_full", w_in_ready, 1'b0);
    w_rst_n = 1'b0;
    cyc();
    chk1("wrap_reset_valid", w_out_valid, 1'b0);
    chk("wrap_reset_addr", w_out_addr, 32'h0);
    chk1("wrap_no_halt", w_halted, 1'b0);
    chk1("wrap_no_err", w_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
